maxpool_2x2: RTL

MAXPOOL_2X2 -- requirements
Module: maxpool_2x2

---
 rtl/lenet_pkg.sv | 15 +
 rtl/pool_line_buf.sv | 31 +++
 rtl/maxpool_2x2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator constants: default datapath sizes and the pooling FSM encoding.
package lenet_pkg;

    localparam int unsigned LENET_DATA_W = 8;
    localparam int unsigned LENET_MAX_W  = 28;
    localparam int unsigned CFG_W        = 5;

    typedef logic [1:0] pool_state_t;

    localparam pool_state_t ST_IDLE  = 2'd0;
    localparam pool_state_t ST_RUN   = 2'd1;
    localparam pool_state_t ST_FLUSH = 2'd2;
    localparam pool_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/pool_line_buf.sv
// Row buffer for 2x2 pooling: holds one horizontal pair-max per column pair of the even row.
module pool_line_buf #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 14,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are always rewritten on the even row before the odd row reads them.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we && (32'(waddr) < DEPTH)) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (32'(raddr) < DEPTH) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 stride-2 max pooling over a raster-order feature map with valid/ready handshakes.
module maxpool_2x2
    import lenet_pkg::*;
#(
    parameter int unsigned DATA_W = LENET_DATA_W,
    parameter int unsigned MAX_W  = LENET_MAX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CFG_W-1:0]  cfg_width,
    input  logic [CFG_W-1:0]  cfg_height,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LB_DEPTH = MAX_W / 2;
    localparam int unsigned LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

    pool_state_t       state_q, state_d;
    logic [CFG_W-1:0]  col_q, col_d;
    logic [CFG_W-1:0]  row_q, row_d;
    logic [CFG_W-1:0]  width_q, width_d;
    logic [CFG_W-1:0]  height_q, height_d;
    logic [DATA_W-1:0] pair_q, pair_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic              accept;
    logic              last_col;
    logic              last_row;
    logic [CFG_W-1:0]  col_half;
    logic [LB_AW-1:0]  lb_addr;
    logic              lb_we;
    logic [DATA_W-1:0] lb_rdata;
    logic [DATA_W-1:0] hmax;
    logic [DATA_W-1:0] vmax;

    assign in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
    assign done      = (state_q == ST_DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    assign last_col = (col_q == width_q - CFG_W'(1));
    assign last_row = (row_q == height_q - CFG_W'(1));
    assign col_half = col_q >> 1;
    assign lb_addr  = col_half[LB_AW-1:0];

    assign hmax = (in_data > pair_q) ? in_data : pair_q;
    assign vmax = (hmax > lb_rdata) ? hmax : lb_rdata;

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (LB_DEPTH),
        .AW     (LB_AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (hmax),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        width_d     = width_q;
        height_d    = height_q;
        pair_d      = pair_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lb_we       = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    width_d  = cfg_width;
                    height_d = cfg_height;
                    col_d    = '0;
                    row_d    = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    // Even column opens a pair; odd column closes it into the buffer or output.
                    if (!col_q[0]) begin
                        pair_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = vmax;
                    end

                    if (last_col) begin
                        col_d = '0;
                        row_d = row_q + CFG_W'(1);
                        if (last_row) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        col_d = col_q + CFG_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (!out_valid_q || out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            pair_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            width_q     <= width_d;
            height_q    <= height_d;
            pair_q      <= pair_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
